// File: rtl/bram_frame_reader_if.sv
// rtl/bram_frame_reader_if.sv - word stream from the frame reader to its downstream consumer
interface bram_frame_reader_if #(
  parameter int WORD_LENGTH = 16
) ();
  logic [WORD_LENGTH-1:0] outData;
  logic                   outValid;
  logic                   outReady;

  modport master (output outData, output outValid, input outReady);
  modport slave  (input outData, input outValid, output outReady);
endinterface

// File: rtl/bram_frame_reader.sv
// rtl/bram_frame_reader.sv - sequential block-RAM read engine with prefetch FIFO and backpressured output
module bram_frame_reader #(
  parameter int WORD_LENGTH = 16,
  parameter int ADDR_WIDTH  = 17,
  parameter int MEM_DEPTH   = 125001,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_WIDTH-1:0]  baseAddress,
  input  logic [ADDR_WIDTH-1:0]  wordCount,
  output logic                   busy,
  output logic                   done,
  output logic                   bramEnable,
  output logic                   bramWriteEnable,
  output logic [ADDR_WIDTH-1:0]  bramAddress,
  input  logic [WORD_LENGTH-1:0] bramDataIn,
  bram_frame_reader_if.master    stream
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_next;

  logic [ADDR_WIDTH-1:0]  address, remaining;
  logic                   in_flight;
  logic                   done_q;
  logic [WORD_LENGTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [CNT_W-1:0]       count, count_after_pop, count_next;
  logic                   valid, push, pop, issue, finish, zero_start;

  assign valid           = (count != '0);
  assign pop             = valid && stream.outReady;
  assign push            = in_flight;
  assign count_after_pop = count - CNT_W'(pop);
  assign count_next      = count_after_pop + CNT_W'(push);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  // A read is only issued when the FIFO is guaranteed room for it one cycle later
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    finish     = 1'b0;
    zero_start = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (wordCount == '0) zero_start = 1'b1;
            else                 state_next = FETCH;
          end
        end
        FETCH: begin
          if (count_after_pop + CNT_W'(in_flight) < CNT_W'(FIFO_DEPTH)) begin
            issue = 1'b1;
            if (remaining == ADDR_WIDTH'(1)) state_next = DRAIN;
          end
        end
        DRAIN: begin
          if (!in_flight && count_next == '0) begin
            finish     = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      address   <= '0;
      remaining <= '0;
      in_flight <= 1'b0;
      done_q    <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      done_q    <= zero_start || finish;
      in_flight <= issue;
      if (abort) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count_next;
      end
      if (state == IDLE && start && !abort) begin
        address   <= baseAddress;
        remaining <= wordCount;
      end else if (issue) begin
        address   <= (address == LAST_ADDR) ? '0 : address + ADDR_WIDTH'(1);
        remaining <= remaining - ADDR_WIDTH'(1);
      end
    end
  end

  // Storage needs no reset: outData is gated by valid, so stale entries never show
  always_ff @(posedge clock) begin
    if (push && !abort) fifo_mem[wr_ptr] <= bramDataIn;
  end

  assign busy            = (state != IDLE);
  assign done            = done_q;
  assign bramEnable      = issue;
  assign bramWriteEnable = 1'b0;
  assign bramAddress     = issue ? address : '0;
  assign stream.outValid = valid;
  assign stream.outData  = valid ? fifo_mem[rd_ptr] : '0;
endmodule
